// File: rtl/axis_rms_threshold_monitor.sv
// axis_rms_threshold_monitor: debounced over/under-level classifier with hysteresis,
// saturating fault counter and a one-deep AXI-Stream register slice.
module axis_rms_threshold_monitor #(
  parameter int inout_width       = 16,
  parameter int inout_fractional  = 15,
  parameter int debounce_count    = 4,
  parameter int fault_count_width = 16
) (
  input  logic                         aclk,
  input  logic                         resetn,
  input  logic [inout_width-1:0]       s_axis_tdata,
  input  logic                         s_axis_tvalid,
  output logic                         s_axis_tready,
  output logic [inout_width-1:0]       m_axis_tdata,
  output logic                         m_axis_tvalid,
  input  logic                         m_axis_tready,
  input  logic [inout_width-1:0]       over_set_th,
  input  logic [inout_width-1:0]       over_clear_th,
  input  logic [inout_width-1:0]       under_set_th,
  input  logic [inout_width-1:0]       under_clear_th,
  input  logic                         clear_count,
  output logic                         over_flag,
  output logic                         under_flag,
  output logic                         fault_event,
  output logic [fault_count_width-1:0] fault_count
);
  if (debounce_count < 1 || debounce_count > 255 || inout_fractional > inout_width) begin : g_bad_param
    $error("axis_rms_threshold_monitor: illegal parameter value");
  end
  typedef enum logic [2:0] {NORMAL, OVER_PEND, OVER, UNDER_PEND, UNDER} state_t;
  localparam logic [7:0] deb = 8'(debounce_count);
  state_t                       state_q, state_d;
  logic [7:0]                   cnt_q, cnt_d, inc;
  logic [inout_width-1:0]       tdata_q;
  logic                         tvalid_q, over_q, under_q, event_q;
  logic [fault_count_width-1:0] count_q;
  logic                         accept, hi, lo, enter;
  assign s_axis_tready = !tvalid_q || m_axis_tready;
  assign accept        = s_axis_tvalid && s_axis_tready;
  assign hi            = s_axis_tdata >= over_set_th;
  assign lo            = s_axis_tdata <= under_set_th;
  assign inc           = cnt_q + 8'd1;
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      NORMAL: if (hi || lo) begin
        cnt_d   = 8'd1;
        state_d = hi ? (deb == 8'd1 ? OVER : OVER_PEND) : (deb == 8'd1 ? UNDER : UNDER_PEND);
      end
      OVER_PEND: begin
        cnt_d   = hi ? inc : 8'd0;
        state_d = !hi ? NORMAL : (inc == deb ? OVER : OVER_PEND);
      end
      UNDER_PEND: begin
        cnt_d   = lo ? inc : 8'd0;
        state_d = !lo ? NORMAL : (inc == deb ? UNDER : UNDER_PEND);
      end
      OVER:    state_d = s_axis_tdata < over_clear_th ? NORMAL : OVER;
      UNDER:   state_d = s_axis_tdata > under_clear_th ? NORMAL : UNDER;
      default: state_d = NORMAL;
    endcase
    if (state_d == OVER || state_d == UNDER) cnt_d = 8'd0;
  end
  // OVER and UNDER are never adjacent, so any arrival into them from elsewhere is an entry
  assign enter = accept && ((state_d == OVER && state_q != OVER) || (state_d == UNDER && state_q != UNDER));
  always_ff @(posedge aclk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= NORMAL;
      cnt_q    <= 8'd0;
      tdata_q  <= '0;
      tvalid_q <= 1'b0;
      over_q   <= 1'b0;
      under_q  <= 1'b0;
      event_q  <= 1'b0;
      count_q  <= '0;
    end else begin
      if (accept) begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        tdata_q <= s_axis_tdata;
        over_q  <= state_d == OVER;
        under_q <= state_d == UNDER;
      end
      tvalid_q <= accept || (tvalid_q && !m_axis_tready);
      event_q  <= enter;
      count_q  <= clear_count ? '0 : (enter && !(&count_q)) ? count_q + 1'b1 : count_q;
    end
  end
  assign m_axis_tdata  = tdata_q;
  assign m_axis_tvalid = tvalid_q;
  assign over_flag     = over_q;
  assign under_flag    = under_q;
  assign fault_event   = event_q;
  assign fault_count   = count_q;
endmodule

// File: tb/tb_axis_rms_threshold_monitor.sv
// tb_axis_rms_threshold_monitor: directed and randomized checks of two monitor instances
// (debounce 4 and debounce 1, 2-bit fault counter) against a level/run-length reference model.
module tb_axis_rms_threshold_monitor;
  logic        aclk = 1'b0, resetn = 1'b0;
  always #5 aclk = ~aclk;
  logic [15:0] s_tdata = '0, os = 16'h6000, oc = 16'h5800, us = 16'h1000, uc = 16'h1800;
  logic        s_tvalid = 1'b0, m_tready = 1'b1, clear = 1'b0;
  logic [15:0] m_tdata [2];
  logic        m_tvalid [2], s_tready [2], ovf [2], unf [2], evt [2];
  logic [1:0]  fc [2];
  axis_rms_threshold_monitor #(.debounce_count(4), .fault_count_width(2)) u0 (
    .aclk(aclk), .resetn(resetn), .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid),
    .s_axis_tready(s_tready[0]), .m_axis_tdata(m_tdata[0]), .m_axis_tvalid(m_tvalid[0]),
    .m_axis_tready(m_tready), .over_set_th(os), .over_clear_th(oc), .under_set_th(us),
    .under_clear_th(uc), .clear_count(clear), .over_flag(ovf[0]), .under_flag(unf[0]),
    .fault_event(evt[0]), .fault_count(fc[0]));
  axis_rms_threshold_monitor #(.debounce_count(1), .fault_count_width(2)) u1 (
    .aclk(aclk), .resetn(resetn), .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid),
    .s_axis_tready(s_tready[1]), .m_axis_tdata(m_tdata[1]), .m_axis_tvalid(m_tvalid[1]),
    .m_axis_tready(m_tready), .over_set_th(os), .over_clear_th(oc), .under_set_th(us),
    .under_clear_th(uc), .clear_count(clear), .over_flag(ovf[1]), .under_flag(unf[1]),
    .fault_event(evt[1]), .fault_count(fc[1]));
  int n_cmp = 0, n_err = 0;
  int lvl [2], run [2], pk [2], cnt [2];
  int deb [2] = '{4, 1};
  bit exp_evt [2];
  logic [15:0] exp_data = '0;
  bit exp_valid = 0;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      lvl[k] = 0; run[k] = 0; pk[k] = 0; cnt[k] = 0; exp_evt[k] = 0;
    end
    exp_valid = 0;
    exp_data  = '0;
  endtask
  // lvl: 0 normal, 1 over latched, 2 under latched; run counts consecutive qualifying samples of kind pk
  task automatic step(input bit acc, input logic [15:0] x);
    for (int k = 0; k < 2; k++) begin
      exp_evt[k] = 0;
      if (acc) begin
        if (lvl[k] == 1) begin
          if (x < oc) lvl[k] = 0;
        end else if (lvl[k] == 2) begin
          if (x > uc) lvl[k] = 0;
        end else begin
          if (run[k] != 0) run[k] = ((pk[k] == 1 && x >= os) || (pk[k] == 2 && x <= us)) ? run[k] + 1 : 0;
          else if (x >= os) begin pk[k] = 1; run[k] = 1; end
          else if (x <= us) begin pk[k] = 2; run[k] = 1; end
          if (run[k] == deb[k]) begin lvl[k] = pk[k]; run[k] = 0; exp_evt[k] = 1; end
        end
      end
      if (clear) cnt[k] = 0;
      else if (exp_evt[k] && cnt[k] < 3) cnt[k]++;
    end
  endtask
  task automatic check(input string tag);
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("%s u%0d tvalid", tag, k), m_tvalid[k], exp_valid);
      if (exp_valid) chk($sformatf("%s u%0d tdata", tag, k), m_tdata[k], exp_data);
      chk($sformatf("%s u%0d over_flag", tag, k), ovf[k], lvl[k] == 1);
      chk($sformatf("%s u%0d under_flag", tag, k), unf[k], lvl[k] == 2);
      chk($sformatf("%s u%0d fault_event", tag, k), evt[k], exp_evt[k]);
      chk($sformatf("%s u%0d fault_count", tag, k), fc[k], cnt[k]);
    end
  endtask
  task automatic send(input logic [15:0] x, input bit clr = 0);
    @(negedge aclk);
    s_tdata = x; s_tvalid = 1'b1; clear = clr;
    @(posedge aclk);
    step(1, x);
    exp_data = x; exp_valid = 1;
    #1 check($sformatf("send %h", x));
    s_tvalid = 1'b0; clear = 1'b0;
  endtask
  task automatic idle(input int n);
    repeat (n) begin
      @(negedge aclk);
      s_tvalid = 1'b0; clear = 1'b0;
      @(posedge aclk);
      step(0, s_tdata);
      exp_valid = 0;
      #1 check("idle");
    end
  endtask
  function automatic logic [15:0] pick();
    logic [15:0] base;
    case ($urandom_range(0, 4))
      0: base = os;
      1: base = oc;
      2: base = us;
      3: base = uc;
      default: base = 16'($urandom_range(0, 16'hFFFF));
    endcase
    return base + 16'($urandom_range(0, 4)) - 16'd2;
  endfunction
  initial begin
    model_reset();
    repeat (10) @(posedge aclk);
    @(negedge aclk) resetn = 1'b1;
    #1 check("reset");
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("reset u%0d tdata", k), m_tdata[k], 16'h0);
      chk($sformatf("reset u%0d s_tready", k), s_tready[k], 1'b1);
    end
    repeat (3) send(16'h6100);
    send(16'h5000);
    repeat (4) send(16'h6100);
    idle(1);
    send(16'h5900);
    send(16'h57FF);
    repeat (4) send(16'h0F00);
    send(16'h1800);
    send(16'h1801);
    idle(1);
    send(16'h3000);
    @(negedge aclk);
    m_tready = 1'b0; s_tdata = 16'h6100; s_tvalid = 1'b1;
    #1 for (int k = 0; k < 2; k++) chk($sformatf("stall u%0d s_tready", k), s_tready[k], 1'b0);
    repeat (3) begin
      @(posedge aclk);
      step(0, s_tdata);
      #1 check("stall");
    end
    @(negedge aclk) m_tready = 1'b1;
    @(posedge aclk);
    step(1, 16'h6100);
    exp_data = 16'h6100; exp_valid = 1;
    #1 check("drain+accept");
    s_tvalid = 1'b0;
    send(16'h5000);
    idle(1);
    repeat (3) send(16'h6100);
    @(negedge aclk) resetn = 1'b0;
    #1 model_reset();
    check("async reset");
    @(negedge aclk) resetn = 1'b1;
    send(16'h6100);
    send(16'h5000);
    repeat (5) begin
      repeat (4) send(16'h6100);
      send(16'h5000);
    end
    repeat (3) send(16'h6100);
    send(16'h6100, 1);
    send(16'h5000);
    idle(1);
    for (int i = 0; i < 400; i++) begin
      if (i % 50 == 0) begin
        @(negedge aclk);
        os = 16'($urandom_range(16'h4000, 16'hC000));
        oc = ($urandom_range(0, 7) == 0) ? os + 16'h100 : os - 16'($urandom_range(0, 16'h1000));
        us = 16'($urandom_range(16'h0800, 16'h3000));
        uc = ($urandom_range(0, 7) == 0) ? us - 16'h100 : us + 16'($urandom_range(0, 16'h1000));
      end
      if ($urandom_range(0, 3) == 0) idle(1);
      else send(pick(), $urandom_range(0, 15) == 0);
    end
    idle(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/axis_rms_threshold_monitor.md
Name: axis_rms_threshold_monitor

Overview:
Downstream consumer of the true-RMS stage. It takes the unsigned RMS stream and classifies it against programmable over- and under-level thresholds, using hysteresis and a consecutive-sample debounce. It raises level flags and one-cycle event pulses, keeps a saturating fault counter, and forwards each RMS sample through a one-deep register slice to the next consumer (logging or protection logic).

Parameters:
inout_width, 16, width of RMS data and of all threshold ports (unsigned).
inout_fractional, 15, fractional bits of data/thresholds; documentation only, no arithmetic depends on it.
debounce_count, 4, consecutive qualifying samples needed to assert a fault; legal range 1..255.
fault_count_width, 16, width of the saturating fault counter.

Ports:
aclk  in  1  clock.
resetn  in  1  asynchronous active-low reset.
s_axis_tdata  in  inout_width  RMS sample, unsigned.
s_axis_tvalid  in  1  sample valid.
s_axis_tready  out  1  ready; high when (!m_axis_tvalid || m_axis_tready).
m_axis_tdata  out  inout_width  registered copy of the accepted sample.
m_axis_tvalid  out  1  output valid.
m_axis_tready  in  1  downstream ready.
over_set_th  in  inout_width  over-level assert threshold (compare >=).
over_clear_th  in  inout_width  over-level release threshold (compare <); must be <= over_set_th.
under_set_th  in  inout_width  under-level assert threshold (compare <=).
under_clear_th  in  inout_width  under-level release threshold (compare >); must be >= under_set_th.
clear_count  in  1  synchronous clear of fault_count.
over_flag  out  1  level: over-voltage condition latched.
under_flag  out  1  level: under-voltage condition latched.
fault_event  out  1  one-cycle pulse on entry to OVER or UNDER.
fault_count  out  fault_count_width  saturating count of fault entries.

Behaviour:
- Reset (resetn low, async): state NORMAL; debounce counter 0; m_axis_tvalid 0; m_axis_tdata 0; over_flag, under_flag and fault_event 0; fault_count 0. Resetn low in the middle of a pending debounce discards it.
- Accept: a sample is accepted when s_axis_tvalid && s_axis_tready. Only accepted samples advance the FSM or the counter.
- Output slice: on accept, m_axis_tdata <= sample and m_axis_tvalid <= 1 on the next edge (latency 1). m_axis_tvalid clears when m_axis_tready is high and no new accept occurs in that cycle. Simultaneous drain and accept keeps tvalid high with the new data. m_axis_tdata holds stable while tvalid && !tready.
- Flags, fault_event and fault_count update on the same edge that loads m_axis_tdata for the sample that caused them.
- FSM states: NORMAL, OVER_PEND, OVER, UNDER_PEND, UNDER. Per accepted sample x:
  NORMAL: x >= over_set_th -> OVER_PEND, cnt=1. Else x <= under_set_th -> UNDER_PEND, cnt=1. Over is checked first when both hold.
  OVER_PEND: x >= over_set_th -> cnt+1. Reaching debounce_count -> OVER. Otherwise -> NORMAL, cnt=0.
  UNDER_PEND: mirror of OVER_PEND using x <= under_set_th, terminating in UNDER.
  OVER: over_flag=1. x < over_clear_th -> NORMAL, flag drops on that edge. No debounce on release.
  UNDER: under_flag=1. x > under_clear_th -> NORMAL, flag drops.
- debounce_count == 1: NORMAL goes directly to OVER/UNDER on the first qualifying sample, with no PEND cycle.
- fault_event pulses exactly one cycle on each transition into OVER or UNDER. It never pulses on release.
- fault_count increments by 1 with each fault_event and saturates at all-ones. clear_count has priority over an increment in the same cycle (result is 0).
- Threshold ports are sampled at each accept and may change at any time. Misordered thresholds are not an error: the rules above apply literally.
- The debounce counter is 8 bits and never exceeds debounce_count.

Test Plan:
- Reset/idle: hold resetn low 10 cycles, then release with no tvalid -> all outputs 0, s_axis_tready=1.
- Over debounce (debounce_count=4, over_set=0x6000, over_clear=0x5800): send 0x6100 x3, then 0x5000 -> no flag, state NORMAL. Then send 0x6100 x4 -> over_flag rises with the 4th sample's m_axis_tvalid, fault_event 1 cycle, fault_count=1.
- Hysteresis: from OVER, send 0x5900 -> over_flag stays 1. Send 0x57FF -> over_flag 0, fault_count stays 1.
- Under path (under_set=0x1000, under_clear=0x1800): 4x 0x0F00 -> under_flag=1, fault_count+1. Then 0x1800 -> still set. Then 0x1801 -> cleared.
- Backpressure: hold m_axis_tready=0 with a sample present -> s_axis_tready=0, m_axis_tdata stable, FSM frozen despite tvalid. Release -> sample order preserved, no sample lost or duplicated.
- Saturation/clear (fault_count_width=2): produce 5 fault entries -> fault_count=3. Assert clear_count together with a 6th fault_event -> fault_count=0.
